uncache_ctrl: RTL and testbench

Sequencing controller for uncached (MMIO/device) accesses from the LSU. It accepts one request at a time and runs a single-beat AXI read (AR/R) or write (AW/W/B) transaction. It returns a registered response to the LSU and bounds every transaction with a watchdog timeout. It sits between the LSU uncache path and the AXI crossbar, in parallel with the D-cache refill path.

---
 rtl/uncache_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_uncache_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncache_ctrl.sv
// -----------------------------------------------------------------------------
// uncache_ctrl
//
// Sequencer for uncached (MMIO/device) LSU accesses. It takes one request at a
// time and turns it into a single-beat AXI read (AR/R) or write (AW/W/B). It
// then returns a one-cycle registered response to the LSU. A per-state
// watchdog aborts any transaction whose slave stalls too long.
//
// Parameters
//   ADDR_W   request / AXI address width
//   DATA_W   data bus width
//   TIMEOUT  max cycles spent in any busy state before abort (0 = no watchdog)
//
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req_valid/req_ready              LSU request handshake (ready only in IDLE)
//   req_wen, req_addr, req_size      request kind, byte address, AXI size
//   req_wdata, req_wstrb             lane-aligned write data and strobes
//   resp_valid, resp_rdata, resp_err one-cycle response pulse, no backpressure
//   ar_*/r_*                         AXI read address / read data channels
//   aw_*/w_*/b_*                     AXI write address / data / response channels
// -----------------------------------------------------------------------------
module uncache_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [2:0]            req_size,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,

    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,

    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic [2:0]            ar_size,

    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [DATA_W-1:0]     r_data,
    input  logic [1:0]            r_resp,

    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [ADDR_W-1:0]     aw_addr,
    output logic [2:0]            aw_size,

    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_W-1:0]     w_data,
    output logic [DATA_W/8-1:0]   w_strb,

    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [1:0]            b_resp
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP,
        DONE
    } state_t;

    // Timer only has to reach TIMEOUT-1; the state always changes at that point.
    localparam int             TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMAX = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                state;
    state_t                state_nxt;
    logic [TW-1:0]         timer;
    logic                  aw_done;
    logic                  w_done;

    logic [ADDR_W-1:0]     addr_q;
    logic [2:0]            size_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [DATA_W/8-1:0]   wstrb_q;

    logic                  hs_aw;
    logic                  hs_w;
    logic                  wr_both;
    logic                  timeout_hit;
    logic                  tmo;
    logic [DATA_W-1:0]     rsp_rdata_nxt;
    logic                  rsp_err_nxt;

    // AW and W complete independently; the write request phase ends once both
    // have completed, whether in this cycle or in an earlier one.
    assign hs_aw   = (state == WR_REQ) && !aw_done && aw_ready;
    assign hs_w    = (state == WR_REQ) && !w_done && w_ready;
    assign wr_both = (aw_done || hs_aw) && (w_done || hs_w);

    // >= rather than == so a wrapped or stale timer can never slip past the limit.
    assign timeout_hit = (TIMEOUT != 0) && (timer >= TMAX);

    // Next-state logic. A completing handshake is checked before the timeout so
    // it wins when both happen in the same cycle.
    always_comb begin
        state_nxt = state;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nxt = req_wen ? WR_REQ : RD_ADDR;
                end
            end
            RD_ADDR: begin
                if (ar_ready) begin
                    state_nxt = RD_DATA;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            RD_DATA: begin
                if (r_valid) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            WR_REQ: begin
                if (wr_both) begin
                    state_nxt = WR_RESP;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            WR_RESP: begin
                if (b_valid) begin
                    state_nxt = DONE;
                end else if (timeout_hit) begin
                    state_nxt = DONE;
                    tmo       = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Response value loaded on entry to DONE. Read data is zeroed on any error.
    always_comb begin
        rsp_rdata_nxt = '0;
        rsp_err_nxt   = 1'b0;
        if (tmo) begin
            rsp_err_nxt = 1'b1;
        end else if (state == RD_DATA) begin
            rsp_err_nxt   = (r_resp != 2'b00);
            rsp_rdata_nxt = (r_resp == 2'b00) ? r_data : '0;
        end else if (state == WR_RESP) begin
            rsp_err_nxt = (b_resp != 2'b00);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            timer      <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            // Watchdog counts time spent in the current state only.
            if (state == IDLE || state_nxt != state) begin
                timer <= '0;
            end else begin
                timer <= timer + TW'(1);
            end
            if (state == WR_REQ && state_nxt == WR_REQ) begin
                aw_done <= aw_done || hs_aw;
                w_done  <= w_done || hs_w;
            end else begin
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            resp_valid <= (state_nxt == DONE);
            resp_rdata <= (state_nxt == DONE) ? rsp_rdata_nxt : '0;
            resp_err   <= (state_nxt == DONE) ? rsp_err_nxt : 1'b0;
        end
    end

    // Request fields are only consumed while busy, so they need no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            size_q  <= req_size;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    assign req_ready = (state == IDLE);

    assign ar_valid  = (state == RD_ADDR);
    assign ar_addr   = addr_q;
    assign ar_size   = size_q;
    assign r_ready   = (state == RD_DATA);

    assign aw_valid  = (state == WR_REQ) && !aw_done;
    assign aw_addr   = addr_q;
    assign aw_size   = size_q;
    assign w_valid   = (state == WR_REQ) && !w_done;
    assign w_data    = wdata_q;
    assign w_strb    = wstrb_q;
    assign b_ready   = (state == WR_RESP);

endmodule

// File: tb/tb_uncache_ctrl.sv
module tb_uncache_ctrl;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int TO     = 8;

    logic                 clk;
    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_wen;
    logic [ADDR_W-1:0]    req_addr;
    logic [2:0]           req_size;
    logic [DATA_W-1:0]    req_wdata;
    logic [DATA_W/8-1:0]  req_wstrb;
    logic                 resp_valid;
    logic [DATA_W-1:0]    resp_rdata;
    logic                 resp_err;
    logic                 ar_valid;
    logic                 ar_ready;
    logic [ADDR_W-1:0]    ar_addr;
    logic [2:0]           ar_size;
    logic                 r_valid;
    logic                 r_ready;
    logic [DATA_W-1:0]    r_data;
    logic [1:0]           r_resp;
    logic                 aw_valid;
    logic                 aw_ready;
    logic [ADDR_W-1:0]    aw_addr;
    logic [2:0]           aw_size;
    logic                 w_valid;
    logic                 w_ready;
    logic [DATA_W-1:0]    w_data;
    logic [DATA_W/8-1:0]  w_strb;
    logic                 b_valid;
    logic                 b_ready;
    logic [1:0]           b_resp;

    int n_assert = 0;
    int n_fail   = 0;

    uncache_ctrl #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wen    (req_wen),
        .req_addr   (req_addr),
        .req_size   (req_size),
        .req_wdata  (req_wdata),
        .req_wstrb  (req_wstrb),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ar_valid   (ar_valid),
        .ar_ready   (ar_ready),
        .ar_addr    (ar_addr),
        .ar_size    (ar_size),
        .r_valid    (r_valid),
        .r_ready    (r_ready),
        .r_data     (r_data),
        .r_resp     (r_resp),
        .aw_valid   (aw_valid),
        .aw_ready   (aw_ready),
        .aw_addr    (aw_addr),
        .aw_size    (aw_size),
        .w_valid    (w_valid),
        .w_ready    (w_ready),
        .w_data     (w_data),
        .w_strb     (w_strb),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_resp     (b_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic slave_idle();
        ar_ready = 1'b0;
        r_valid  = 1'b0;
        r_data   = '0;
        r_resp   = 2'b00;
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        b_valid  = 1'b0;
        b_resp   = 2'b00;
    endtask

    // Called at a negedge with the DUT idle. Slave accepts AR on the (ard+1)th
    // cycle of ar_valid and returns R on the (rd+1)th cycle of r_ready.
    task automatic do_read(input logic [63:0] addr, input logic [2:0] size,
                           input int ard, input int rd,
                           input logic [63:0] data, input logic [1:0] rresp,
                           input bit hold, input logic [63:0] nxt_addr);
        int          arcnt = 0;
        int          rcnt  = 0;
        int          lat   = -1;
        int          exp_lat;
        int          exp_arcnt;
        int          exp_rcnt;
        logic [63:0] exp_rdata;
        logic        exp_err;
        logic [63:0] got_rdata = '0;
        logic        got_err = 1'b0;
        bit          busy_ok = 1'b1;
        bit          addr_ok = 1'b1;

        // Reference: total latency is the sum of per-phase waits, clipped by the watchdog.
        if (ard >= TO) begin
            exp_lat = 1 + TO; exp_err = 1'b1; exp_rdata = '0;
            exp_arcnt = TO; exp_rcnt = 0;
        end else if (rd >= TO) begin
            exp_lat = 2 + ard + TO; exp_err = 1'b1; exp_rdata = '0;
            exp_arcnt = ard + 1; exp_rcnt = TO;
        end else begin
            exp_lat = 3 + ard + rd; exp_err = (rresp != 2'b00);
            exp_rdata = exp_err ? 64'd0 : data;
            exp_arcnt = ard + 1; exp_rcnt = rd + 1;
        end

        chk("rd_req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wen   = 1'b0;
        req_addr  = addr;
        req_size  = size;
        req_wdata = {$urandom, $urandom};
        req_wstrb = 8'($urandom);

        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                if (hold) req_addr = nxt_addr;
                else      req_valid = 1'b0;
            end
            if (req_ready) busy_ok = 1'b0;
            if (ar_valid) begin
                arcnt++;
                if (ar_addr !== addr || ar_size !== size) addr_ok = 1'b0;
                ar_ready = (arcnt == ard + 1);
            end else begin
                ar_ready = 1'b0;
            end
            if (r_ready) begin
                rcnt++;
                r_valid = (rcnt == rd + 1);
            end else begin
                r_valid = 1'b0;
            end
            r_data = r_valid ? data : {$urandom, $urandom};
            r_resp = r_valid ? rresp : 2'($urandom);
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end

        chk("rd_latency", 64'(lat), 64'(exp_lat));
        chk("rd_rdata", got_rdata, exp_rdata);
        chk("rd_err", {63'd0, got_err}, {63'd0, exp_err});
        chk("rd_ar_cycles", 64'(arcnt), 64'(exp_arcnt));
        chk("rd_r_cycles", 64'(rcnt), 64'(exp_rcnt));
        chk("rd_busy_not_ready", {63'd0, busy_ok}, 64'd1);
        chk("rd_ar_fields", {63'd0, addr_ok}, 64'd1);

        @(negedge clk);
        slave_idle();
        chk("rd_resp_one_cycle", {63'd0, resp_valid}, 64'd0);
        chk("rd_back_to_idle", {63'd0, req_ready}, 64'd1);
    endtask

    // Called at a negedge with the DUT idle. AW and W are accepted independently
    // after awd / wd extra cycles; B returns on the (bd+1)th cycle of b_ready.
    task automatic do_write(input logic [63:0] addr, input logic [2:0] size,
                            input int awd, input int wd, input int bd,
                            input logic [63:0] wdata, input logic [7:0] wstrb,
                            input logic [1:0] bresp);
        int   awcnt = 0;
        int   wcnt  = 0;
        int   bcnt  = 0;
        int   lat   = -1;
        int   wmax;
        int   exp_lat;
        int   exp_awcnt;
        int   exp_wcnt;
        int   exp_bcnt;
        logic exp_err;
        logic [63:0] got_rdata = '0;
        logic got_err = 1'b0;
        bit   busy_ok = 1'b1;
        bit   fld_ok  = 1'b1;

        wmax = (awd > wd) ? awd : wd;
        if (wmax >= TO) begin
            exp_lat = 1 + TO; exp_err = 1'b1;
            exp_awcnt = (awd < TO) ? awd + 1 : TO;
            exp_wcnt  = (wd < TO) ? wd + 1 : TO;
            exp_bcnt  = 0;
        end else if (bd >= TO) begin
            exp_lat = 2 + wmax + TO; exp_err = 1'b1;
            exp_awcnt = awd + 1; exp_wcnt = wd + 1; exp_bcnt = TO;
        end else begin
            exp_lat = 3 + wmax + bd; exp_err = (bresp != 2'b00);
            exp_awcnt = awd + 1; exp_wcnt = wd + 1; exp_bcnt = bd + 1;
        end

        chk("wr_req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wen   = 1'b1;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        req_wstrb = wstrb;

        for (int c = 1; c <= 40 && lat < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 1'b0;
                req_wdata = {$urandom, $urandom};
                req_wstrb = 8'($urandom);
            end
            if (req_ready) busy_ok = 1'b0;
            if (aw_valid) begin
                awcnt++;
                if (aw_addr !== addr || aw_size !== size) fld_ok = 1'b0;
                aw_ready = (awcnt == awd + 1);
            end else begin
                aw_ready = 1'b0;
            end
            if (w_valid) begin
                wcnt++;
                if (w_data !== wdata || w_strb !== wstrb) fld_ok = 1'b0;
                w_ready = (wcnt == wd + 1);
            end else begin
                w_ready = 1'b0;
            end
            if (b_ready) begin
                bcnt++;
                b_valid = (bcnt == bd + 1);
            end else begin
                b_valid = 1'b0;
            end
            b_resp = b_valid ? bresp : 2'($urandom);
            if (resp_valid) begin
                lat       = c;
                got_rdata = resp_rdata;
                got_err   = resp_err;
            end
        end

        chk("wr_latency", 64'(lat), 64'(exp_lat));
        chk("wr_rdata_zero", got_rdata, 64'd0);
        chk("wr_err", {63'd0, got_err}, {63'd0, exp_err});
        chk("wr_aw_cycles", 64'(awcnt), 64'(exp_awcnt));
        chk("wr_w_cycles", 64'(wcnt), 64'(exp_wcnt));
        chk("wr_b_cycles", 64'(bcnt), 64'(exp_bcnt));
        chk("wr_busy_not_ready", {63'd0, busy_ok}, 64'd1);
        chk("wr_fields", {63'd0, fld_ok}, 64'd1);

        @(negedge clk);
        slave_idle();
        chk("wr_resp_one_cycle", {63'd0, resp_valid}, 64'd0);
        chk("wr_back_to_idle", {63'd0, req_ready}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_wen   = 1'b0;
        req_addr  = '0;
        req_size  = '0;
        req_wdata = '0;
        req_wstrb = '0;
        slave_idle();
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_req_ready", {63'd0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, resp_valid}, 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_err", {63'd0, resp_err}, 64'd0);
        chk("rst_axi_valids", {59'd0, ar_valid, aw_valid, w_valid, r_ready, b_ready}, 64'd0);

        // Read with slave always ready
        do_read(64'ha000_0048, 3'd3, 0, 0, 64'h1122_3344_5566_7788, 2'b00, 1'b0, 64'd0);

        // Write with split AW/W handshake
        do_write(64'ha000_0100, 3'd2, 0, 3, 1, 64'h0000_0000_dead_beef, 8'h0f, 2'b00);

        // Read error response, write error response
        do_read(64'ha000_0010, 3'd3, 1, 2, 64'hcafe_f00d_1234_5678, 2'b10, 1'b0, 64'd0);
        do_write(64'ha000_0200, 3'd3, 1, 0, 0, 64'h0123_4567_89ab_cdef, 8'hff, 2'b11);

        // Watchdog: AR never accepted, then a normal request follows
        do_read(64'ha000_0300, 3'd3, 50, 0, 64'h5555_aaaa_5555_aaaa, 2'b00, 1'b0, 64'd0);
        do_read(64'ha000_0308, 3'd2, 0, 0, 64'h0000_0000_1357_9bdf, 2'b00, 1'b0, 64'd0);

        // Handshake on the last allowed cycle beats the watchdog
        do_read(64'ha000_0310, 3'd1, TO - 1, TO - 1, 64'h8888_7777_6666_5555, 2'b00, 1'b0, 64'd0);
        do_write(64'ha000_0318, 3'd0, TO - 1, 2, 30, 64'h11, 8'h01, 2'b00);

        // Reset during a write, late B ignored
        chk("mid_req_ready", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'ha000_0400; req_size = 3'd3;
        req_wdata = 64'h99; req_wstrb = 8'hff;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_aw_valid", {63'd0, aw_valid}, 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_aw_valid", {63'd0, aw_valid}, 64'd0);
        chk("mid_rst_w_valid", {63'd0, w_valid}, 64'd0);
        chk("mid_rst_req_ready", {63'd0, req_ready}, 64'd1);
        b_valid = 1'b1; b_resp = 2'b00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_late_b_no_resp", {63'd0, resp_valid}, 64'd0);
            chk("mid_late_b_ready", {63'd0, b_ready}, 64'd0);
        end
        slave_idle();

        // Back-to-back reads with req_valid held
        do_read(64'ha000_0500, 3'd3, 0, 1, 64'h0102_0304_0506_0708, 2'b00, 1'b1, 64'ha000_0508);
        do_read(64'ha000_0508, 3'd3, 0, 0, 64'h1112_1314_1516_1718, 2'b00, 1'b0, 64'd0);

        // Randomized mix
        for (int n = 0; n < 40; n++) begin
            logic [63:0] a;
            logic [63:0] d;
            logic [1:0]  rsp;
            a   = {32'h0000_0000, 32'ha000_0000 | ($urandom & 32'h0000_fff8)};
            d   = {$urandom, $urandom};
            rsp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            if ($urandom_range(0, 1) == 0) begin
                do_read(a, 3'($urandom_range(0, 3)), $urandom_range(0, 10),
                        $urandom_range(0, 10), d, rsp, 1'b0, 64'd0);
            end else begin
                do_write(a, 3'($urandom_range(0, 3)), $urandom_range(0, 10),
                         $urandom_range(0, 10), $urandom_range(0, 10), d,
                         8'($urandom), rsp);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
